// File: rtl/address_gen_loop_nd.sv
// address_gen_loop_nd: three-level nested-loop address generator (iter_out / iter_in / uop).
// For every uop it fetches one micro-op offset, then issues ARRAY_N row reads on a
// valid/ready port. Row order is forward or reversed. Loop offsets are built by
// accumulation, so no multipliers are needed.
module address_gen_loop_nd #(
  parameter int ARRAY_N              = 16,
  parameter int UOP_DATA_WIDTH       = 8,
  parameter int MEM_ADDR_WIDTH_W     = 48,
  parameter int UOP_MEM_ADDR_WIDTH_W = 16,
  parameter int INSN_UOP_W           = 16,
  parameter int INSN_ITER_W          = 16,
  parameter int INSN_FAC_W           = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            row_reverse,
  input  logic [INSN_UOP_W-1:0]           uop_bgn,
  input  logic [INSN_UOP_W-1:0]           uop_end,
  input  logic [INSN_UOP_W-1:0]           uop_step,
  input  logic [INSN_ITER_W-1:0]          iter_in,
  input  logic [INSN_ITER_W-1:0]          iter_out,
  input  logic [INSN_FAC_W-1:0]           factor_in,
  input  logic [INSN_FAC_W-1:0]           factor_out,
  output logic                            busy,
  output logic                            insn_done,
  output logic                            tile_done,
  output logic                            uop_read_req,
  output logic [UOP_MEM_ADDR_WIDTH_W-1:0] uop_read_addr,
  input  logic [UOP_DATA_WIDTH-1:0]       uop_read_data,
  output logic                            mem_read_req,
  output logic [MEM_ADDR_WIDTH_W-1:0]     mem_read_addr,
  input  logic                            mem_read_ready
);

  localparam int ROW_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ARRAY_N - 1);
  localparam logic [MEM_ADDR_WIDTH_W-1:0] ROW_LAST_EXT = MEM_ADDR_WIDTH_W'(ARRAY_N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_UREQ,
    ST_UWAIT,
    ST_ROWS,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic                        cfg_rev_q, cfg_rev_d;
  logic [INSN_UOP_W-1:0]       cfg_bgn_q, cfg_bgn_d;
  logic [INSN_UOP_W-1:0]       cfg_end_q, cfg_end_d;
  logic [INSN_UOP_W-1:0]       cfg_step_q, cfg_step_d;
  logic [INSN_ITER_W-1:0]      cfg_iin_q, cfg_iin_d;
  logic [INSN_ITER_W-1:0]      cfg_iout_q, cfg_iout_d;
  logic [INSN_FAC_W-1:0]       cfg_fin_q, cfg_fin_d;
  logic [INSN_FAC_W-1:0]       cfg_fout_q, cfg_fout_d;
  logic [INSN_UOP_W-1:0]       u_q, u_d;
  logic [INSN_ITER_W-1:0]      ii_q, ii_d;
  logic [INSN_ITER_W-1:0]      io_q, io_d;
  logic [ROW_W-1:0]            row_q, row_d;
  logic [UOP_DATA_WIDTH-1:0]   uop_q, uop_d;
  logic [MEM_ADDR_WIDTH_W-1:0] acc_in_q, acc_in_d;
  logic [MEM_ADDR_WIDTH_W-1:0] acc_out_q, acc_out_d;

  logic [INSN_UOP_W:0]         u_sum;
  logic [INSN_ITER_W:0]        ii_sum;
  logic [INSN_ITER_W:0]        io_sum;
  logic [MEM_ADDR_WIDTH_W-1:0] row_off;
  logic [MEM_ADDR_WIDTH_W-1:0] acc_out_next;
  logic                        beat;
  logic                        last_beat;

  // Uop index sum is one bit wider so a step that overflows still ends the uop loop.
  assign u_sum        = {1'b0, u_q} + {1'b0, cfg_step_q};
  assign ii_sum       = {1'b0, ii_q} + (INSN_ITER_W + 1)'(1);
  assign io_sum       = {1'b0, io_q} + (INSN_ITER_W + 1)'(1);
  assign acc_out_next = acc_out_q + MEM_ADDR_WIDTH_W'(cfg_fout_q);
  assign row_off      = cfg_rev_q ? (ROW_LAST_EXT - MEM_ADDR_WIDTH_W'(row_q))
                                  : MEM_ADDR_WIDTH_W'(row_q);
  assign beat         = (state_q == ST_ROWS) && mem_read_ready;
  assign last_beat    = beat && (row_q == ROW_LAST);

  assign busy          = (state_q != ST_IDLE);
  assign insn_done     = (state_q == ST_DONE);
  assign uop_read_req  = (state_q == ST_UREQ);
  assign uop_read_addr = UOP_MEM_ADDR_WIDTH_W'(u_q);
  assign mem_read_req  = (state_q == ST_ROWS);
  assign tile_done     = last_beat;
  assign mem_read_addr = (state_q == ST_ROWS)
                         ? (acc_in_q + MEM_ADDR_WIDTH_W'(uop_q) + row_off)
                         : '0;

  // Next-state, config capture, row counting and loop advance on each tile's last beat.
  always_comb begin
    state_d    = state_q;
    cfg_rev_d  = cfg_rev_q;
    cfg_bgn_d  = cfg_bgn_q;
    cfg_end_d  = cfg_end_q;
    cfg_step_d = cfg_step_q;
    cfg_iin_d  = cfg_iin_q;
    cfg_iout_d = cfg_iout_q;
    cfg_fin_d  = cfg_fin_q;
    cfg_fout_d = cfg_fout_q;
    u_d        = u_q;
    ii_d       = ii_q;
    io_d       = io_q;
    row_d      = row_q;
    uop_d      = uop_q;
    acc_in_d   = acc_in_q;
    acc_out_d  = acc_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_rev_d  = row_reverse;
          cfg_bgn_d  = uop_bgn;
          cfg_end_d  = uop_end;
          cfg_step_d = (uop_step == '0) ? INSN_UOP_W'(1) : uop_step;
          cfg_iin_d  = iter_in;
          cfg_iout_d = iter_out;
          cfg_fin_d  = factor_in;
          cfg_fout_d = factor_out;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        u_d       = cfg_bgn_q;
        ii_d      = '0;
        io_d      = '0;
        row_d     = '0;
        acc_in_d  = '0;
        acc_out_d = '0;
        if ((cfg_iout_q == '0) || (cfg_iin_q == '0) || (cfg_end_q <= cfg_bgn_q)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_UREQ;
        end
      end
      ST_UREQ: begin
        state_d = ST_UWAIT;
      end
      ST_UWAIT: begin
        uop_d   = uop_read_data;
        row_d   = '0;
        state_d = ST_ROWS;
      end
      ST_ROWS: begin
        if (last_beat) begin
          row_d   = '0;
          state_d = ST_UREQ;
          if (u_sum >= {1'b0, cfg_end_q}) begin
            u_d = cfg_bgn_q;
            if (ii_sum == {1'b0, cfg_iin_q}) begin
              ii_d = '0;
              if (io_sum == {1'b0, cfg_iout_q}) begin
                state_d = ST_DONE;
              end else begin
                io_d      = io_sum[INSN_ITER_W-1:0];
                acc_out_d = acc_out_next;
                acc_in_d  = acc_out_next;
              end
            end else begin
              ii_d     = ii_sum[INSN_ITER_W-1:0];
              acc_in_d = acc_in_q + MEM_ADDR_WIDTH_W'(cfg_fin_q);
            end
          end else begin
            u_d = u_sum[INSN_UOP_W-1:0];
          end
        end else if (beat) begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, config and loop registers; async reset returns everything to zero / IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cfg_rev_q  <= 1'b0;
      cfg_bgn_q  <= '0;
      cfg_end_q  <= '0;
      cfg_step_q <= '0;
      cfg_iin_q  <= '0;
      cfg_iout_q <= '0;
      cfg_fin_q  <= '0;
      cfg_fout_q <= '0;
      u_q        <= '0;
      ii_q       <= '0;
      io_q       <= '0;
      row_q      <= '0;
      uop_q      <= '0;
      acc_in_q   <= '0;
      acc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cfg_rev_q  <= cfg_rev_d;
      cfg_bgn_q  <= cfg_bgn_d;
      cfg_end_q  <= cfg_end_d;
      cfg_step_q <= cfg_step_d;
      cfg_iin_q  <= cfg_iin_d;
      cfg_iout_q <= cfg_iout_d;
      cfg_fin_q  <= cfg_fin_d;
      cfg_fout_q <= cfg_fout_d;
      u_q        <= u_d;
      ii_q       <= ii_d;
      io_q       <= io_d;
      row_q      <= row_d;
      uop_q      <= uop_d;
      acc_in_q   <= acc_in_d;
      acc_out_q  <= acc_out_d;
    end
  end

endmodule

// File: tb/tb_address_gen_loop_nd.sv
// Scoreboard bench for address_gen_loop_nd with ARRAY_N=4: directed instructions push
// expected uop fetch addresses and row-read beats; a monitor pops and compares them.
module tb_address_gen_loop_nd;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        row_reverse;
  logic [15:0] uop_bgn, uop_end, uop_step;
  logic [15:0] iter_in, iter_out;
  logic [15:0] factor_in, factor_out;
  logic        busy, insn_done, tile_done;
  logic        uop_read_req;
  logic [15:0] uop_read_addr;
  logic [7:0]  uop_read_data;
  logic        mem_read_req;
  logic [47:0] mem_read_addr;
  logic        mem_read_ready;

  int          n_vectors = 0;
  int          n_miscompares = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          beat_cnt = 0;
  bit          uop_seen = 0;
  bit          mem_seen = 0;
  bit          stall_prev = 0;
  logic [47:0] stall_addr = '0;
  bit          prev_tile = 0;
  bit          exp_tile_before_done = 0;
  bit          data_mode = 0;
  int          ready_mode = 0;
  int          rdy_idx = 0;
  logic [31:0] rdy_pat = 32'b1010_1010_1010_1010_1010_1000_1010_1010;

  logic [63:0] exp_addr[$];
  bit          exp_last[$];
  logic [63:0] exp_uop[$];

  address_gen_loop_nd #(.ARRAY_N(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .row_reverse   (row_reverse),
    .uop_bgn       (uop_bgn),
    .uop_end       (uop_end),
    .uop_step      (uop_step),
    .iter_in       (iter_in),
    .iter_out      (iter_out),
    .factor_in     (factor_in),
    .factor_out    (factor_out),
    .busy          (busy),
    .insn_done     (insn_done),
    .tile_done     (tile_done),
    .uop_read_req  (uop_read_req),
    .uop_read_addr (uop_read_addr),
    .uop_read_data (uop_read_data),
    .mem_read_req  (mem_read_req),
    .mem_read_addr (mem_read_addr),
    .mem_read_ready(mem_read_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency checks.
  always @(posedge clk) cyc++;

  // Uop memory model: data appears exactly one cycle after the fetch strobe, garbage otherwise.
  always @(posedge clk) begin
    logic        rq;
    logic [15:0] ra;
    rq = uop_read_req;
    ra = uop_read_addr;
    #1;
    uop_read_data = rq ? (data_mode ? ra[7:0] : 8'd8) : 8'hEE;
  end

  // Ready generator: always high, toggling pattern with a 3-cycle low stretch, or held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       mem_read_ready = 1'b1;
      1:       mem_read_ready = rdy_pat[rdy_idx[4:0]];
      default: mem_read_ready = 1'b0;
    endcase
    rdy_idx++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability and done timing.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 0;
      prev_tile  = 0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_req", {63'd0, mem_read_req}, 64'd1);
        checkOutput("stall_addr", {16'd0, mem_read_addr}, {16'd0, stall_addr});
      end
      if (mem_read_req && !mem_seen) begin
        mem_seen = 1;
        checkOutput("first_mem_latency", 64'(cyc - start_cyc), 64'd4);
      end
      if (mem_read_req && mem_read_ready) begin
        beat_cnt++;
        stall_prev = 0;
        if (exp_addr.size() == 0) begin
          checkOutput("unexpected_beat", 64'(exp_addr.size()), 64'd1);
        end else begin
          checkOutput("mem_addr", {16'd0, mem_read_addr}, exp_addr.pop_front());
          checkOutput("tile_done", {63'd0, tile_done}, {63'd0, exp_last.pop_front()});
        end
      end else if (mem_read_req) begin
        stall_prev = 1;
        stall_addr = mem_read_addr;
        checkOutput("stall_tile_done", {63'd0, tile_done}, 64'd0);
      end else begin
        stall_prev = 0;
      end
      if (uop_read_req) begin
        if (!uop_seen) begin
          uop_seen = 1;
          checkOutput("first_uop_latency", 64'(cyc - start_cyc), 64'd2);
        end
        if (exp_uop.size() == 0) begin
          checkOutput("unexpected_uop", 64'(exp_uop.size()), 64'd1);
        end else begin
          checkOutput("uop_addr", {48'd0, uop_read_addr}, exp_uop.pop_front());
        end
      end
      if (insn_done) begin
        checkOutput("done_busy", {63'd0, busy}, 64'd1);
        checkOutput("done_tile_overlap", {63'd0, tile_done}, 64'd0);
        checkOutput("done_after_tile", {63'd0, prev_tile}, {63'd0, exp_tile_before_done});
      end
      prev_tile = tile_done;
    end
  end

  task automatic pushTile(input logic [63:0] uop_addr, input logic [63:0] base, input bit rev);
    exp_uop.push_back(uop_addr);
    for (int r = 0; r < N; r++) begin
      exp_addr.push_back(base + 64'(rev ? (N - 1 - r) : r));
      exp_last.push_back(r == N - 1);
    end
  endtask

  task automatic startInsn(input bit rev, input int bgn, input int en, input int step,
                           input int iin, input int iout, input int fin, input int fout,
                           input bit dmode);
    @(posedge clk);
    #2;
    row_reverse = rev;
    uop_bgn     = 16'(bgn);
    uop_end     = 16'(en);
    uop_step    = 16'(step);
    iter_in     = 16'(iin);
    iter_out    = 16'(iout);
    factor_in   = 16'(fin);
    factor_out  = 16'(fout);
    data_mode   = dmode;
    uop_seen    = 0;
    mem_seen    = 0;
    beat_cnt    = 0;
    start_cyc   = cyc;
    start       = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic waitDone(input int exp_beats, input bit zero_case);
    bit got;
    int done_cyc;
    got = 0;
    done_cyc = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (insn_done) begin
        got = 1;
        done_cyc = cyc;
        break;
      end
    end
    checkOutput("insn_done_seen", {63'd0, got}, 64'd1);
    if (zero_case) checkOutput("done_latency", 64'(done_cyc - start_cyc), 64'd2);
    checkOutput("total_beats", 64'(beat_cnt), 64'(exp_beats));
    checkOutput("leftover_beats", 64'(exp_addr.size()), 64'd0);
    checkOutput("leftover_uops", 64'(exp_uop.size()), 64'd0);
    @(negedge clk);
    checkOutput("busy_after_done", {63'd0, busy}, 64'd0);
    checkOutput("done_single_pulse", {63'd0, insn_done}, 64'd0);
  endtask

  task automatic applyStimulus(input bit rev, input int bgn, input int en, input int step,
                               input int iin, input int iout, input int fin, input int fout,
                               input bit dmode, input int exp_beats);
    exp_tile_before_done = (exp_beats != 0);
    startInsn(rev, bgn, en, step, iin, iout, fin, fout, dmode);
    waitDone(exp_beats, exp_beats == 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    row_reverse = 1'b0;
    uop_bgn = '0; uop_end = '0; uop_step = '0;
    iter_in = '0; iter_out = '0; factor_in = '0; factor_out = '0;
    uop_read_data = '0;
    mem_read_ready = 1'b0;
    #2;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_mem_req", {63'd0, mem_read_req}, 64'd0);
    checkOutput("rst_uop_req", {63'd0, uop_read_req}, 64'd0);
    checkOutput("rst_insn_done", {63'd0, insn_done}, 64'd0);
    checkOutput("rst_mem_addr", {16'd0, mem_read_addr}, 64'd0);
    checkOutput("rst_uop_addr", {48'd0, uop_read_addr}, 64'd0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;

    // Single tile, forward then reversed rows: 8,9,10,11 / 11,10,9,8.
    $display("[TB] single tile forward");
    pushTile(0, 8, 0);
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, 0, 4);
    $display("[TB] single tile reversed");
    pushTile(0, 8, 1);
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 0, 4);

    // Full nest: tile bases 2,4,102,104,1002,1004,1102,1104; a start mid-run must be ignored.
    $display("[TB] nested loops with start while busy");
    pushTile(2, 2, 0);    pushTile(4, 4, 0);
    pushTile(2, 102, 0);  pushTile(4, 104, 0);
    pushTile(2, 1002, 0); pushTile(4, 1004, 0);
    pushTile(2, 1102, 0); pushTile(4, 1104, 0);
    exp_tile_before_done = 1;
    startInsn(0, 2, 6, 2, 2, 2, 100, 1000, 1);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    start = 1'b1; iter_in = 16'd0; factor_in = 16'd7; uop_bgn = 16'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    waitDone(32, 0);

    // Backpressure: toggling ready with a 3-cycle low stretch; bases 8,24,72,88.
    $display("[TB] backpressure");
    ready_mode = 1;
    pushTile(0, 8, 0); pushTile(0, 24, 0); pushTile(0, 72, 0); pushTile(0, 88, 0);
    applyStimulus(0, 0, 1, 1, 2, 2, 16, 64, 0, 16);
    ready_mode = 0;

    // Zero-trip instructions: iter_in=0, then uop_end==uop_bgn.
    $display("[TB] zero-trip instructions");
    applyStimulus(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 3, 3, 1, 1, 1, 0, 0, 0, 0);

    // Step of zero behaves as one: uops 0,1 with data=index -> bases 0,1.
    $display("[TB] zero step");
    pushTile(0, 0, 0); pushTile(1, 1, 0);
    applyStimulus(0, 0, 2, 0, 1, 1, 0, 0, 1, 8);

    // Uop index overflow ends the uop loop: bgn=0xFFFE, step=2 -> one tile at base 254.
    $display("[TB] uop index overflow");
    pushTile(16'hFFFE, 254, 0);
    applyStimulus(0, 16'hFFFE, 16'hFFFF, 2, 1, 1, 0, 0, 1, 4);

    // Reset while stalled in the row phase, then a clean rerun of the single tile.
    $display("[TB] reset mid-rows");
    ready_mode = 2;
    exp_uop.push_back(0);
    startInsn(0, 0, 1, 1, 1, 1, 0, 0, 0);
    begin
      bit seen_req;
      seen_req = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (mem_read_req) begin
          seen_req = 1;
          break;
        end
      end
      checkOutput("reached_rows", {63'd0, seen_req}, 64'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_mem_req", {63'd0, mem_read_req}, 64'd0);
    checkOutput("mid_rst_mem_addr", {16'd0, mem_read_addr}, 64'd0);
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mid_rst_uop_req", {63'd0, uop_read_req}, 64'd0);
    checkOutput("mid_rst_tile_done", {63'd0, tile_done}, 64'd0);
    exp_addr.delete();
    exp_last.delete();
    exp_uop.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("post_rst_no_req", {63'd0, mem_read_req}, 64'd0);
    pushTile(0, 8, 0);
    applyStimulus(0, 0, 1, 1, 1, 1, 0, 0, 0, 4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
